// File: rtl/pdm_cic_decimator_if.sv
`default_nettype none
// ============================================================================
// Module      : pdm_cic_decimator_if
// Description : PDM microphone link and PCM output strobe of the decimator.
// Revision    : 1.0 - initial release
// ============================================================================
interface pdm_cic_decimator_if;
    logic               sclk;
    logic               dat_i;
    logic               en_i;
    logic signed [15:0] pcm_o;
    logic               pcm_valid_o;

    modport master (
        input  dat_i,
        input  en_i,
        output sclk,
        output pcm_o,
        output pcm_valid_o
    );

    modport slave (
        output dat_i,
        output en_i,
        input  sclk,
        input  pcm_o,
        input  pcm_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/pdm_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : pdm_cic_decimator
// Description : PDM bit-clock generator and 3rd-order CIC decimator to 16-bit PCM.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_cic_decimator #(
    parameter int CLK_DIV = 25,
    parameter int DEC     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pdm_cic_decimator_if.master    bus
);

    localparam int c_DEC_W  = $clog2(DEC);
    localparam int c_ACC_W  = 3 * c_DEC_W + 2;
    localparam int c_SHIFT  = c_ACC_W - 17;

    localparam logic [7:0]                c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [c_DEC_W-1:0]        c_DEC_LAST = c_DEC_W'(DEC - 1);
    localparam logic signed [c_ACC_W-1:0] c_PCM_MAX  = c_ACC_W'(32767);
    localparam logic signed [c_ACC_W-1:0] c_PCM_MIN  = c_ACC_W'(-32768);

    logic [7:0]                r_div_cnt;
    logic                      r_sclk;
    logic [1:0]                r_sync;
    logic [c_DEC_W-1:0]        r_dec_cnt;
    logic signed [c_ACC_W-1:0] r_int1, r_int2, r_int3;
    logic signed [c_ACC_W-1:0] r_i3_lat;
    logic signed [c_ACC_W-1:0] r_dly1, r_dly2, r_dly3;
    logic                      r_comb_go;
    logic signed [15:0]        r_pcm;
    logic                      r_pcm_valid;

    logic                      w_div_wrap;
    logic                      w_stb;
    logic signed [c_ACC_W-1:0] w_x;
    logic signed [c_ACC_W-1:0] w_i1n, w_i2n, w_i3n;
    logic signed [c_ACC_W-1:0] w_c1, w_c2, w_c3;
    logic signed [c_ACC_W-1:0] w_scaled;
    logic signed [15:0]        w_pcm_sat;

    assign w_div_wrap = (r_div_cnt == c_DIV_LAST);
    // Sample on the sclk falling transition; the mic drives data on the rise.
    assign w_stb      = bus.en_i & w_div_wrap & r_sclk;

    assign w_x   = r_sync[1] ? {{(c_ACC_W-1){1'b0}}, 1'b1} : {c_ACC_W{1'b1}};
    assign w_i1n = r_int1 + w_x;
    assign w_i2n = r_int2 + w_i1n;
    assign w_i3n = r_int3 + w_i2n;

    assign w_c1     = r_i3_lat - r_dly1;
    assign w_c2     = w_c1 - r_dly2;
    assign w_c3     = w_c2 - r_dly3;
    assign w_scaled = w_c3 >>> c_SHIFT;

    always_comb begin
        w_pcm_sat = w_scaled[15:0];
        if (w_scaled > c_PCM_MAX) begin
            w_pcm_sat = 16'sh7FFF;
        end else if (w_scaled < c_PCM_MIN) begin
            w_pcm_sat = -16'sh8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt   <= '0;
            r_sclk      <= 1'b0;
            r_sync      <= '0;
            r_dec_cnt   <= '0;
            r_int1      <= '0;
            r_int2      <= '0;
            r_int3      <= '0;
            r_i3_lat    <= '0;
            r_dly1      <= '0;
            r_dly2      <= '0;
            r_dly3      <= '0;
            r_comb_go   <= 1'b0;
            r_pcm       <= '0;
            r_pcm_valid <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], bus.dat_i};
            r_pcm_valid <= 1'b0;
            if (!bus.en_i) begin
                // Idle: clear the filter state but keep the last PCM sample.
                r_div_cnt <= '0;
                r_sclk    <= 1'b0;
                r_dec_cnt <= '0;
                r_int1    <= '0;
                r_int2    <= '0;
                r_int3    <= '0;
                r_i3_lat  <= '0;
                r_dly1    <= '0;
                r_dly2    <= '0;
                r_dly3    <= '0;
                r_comb_go <= 1'b0;
            end else begin
                if (w_div_wrap) begin
                    r_div_cnt <= '0;
                    r_sclk    <= ~r_sclk;
                end else begin
                    r_div_cnt <= r_div_cnt + 8'd1;
                end

                r_comb_go <= 1'b0;
                if (w_stb) begin
                    r_int1 <= w_i1n;
                    r_int2 <= w_i2n;
                    r_int3 <= w_i3n;
                    if (r_dec_cnt == c_DEC_LAST) begin
                        r_dec_cnt <= '0;
                        r_i3_lat  <= w_i3n;
                        r_comb_go <= 1'b1;
                    end else begin
                        r_dec_cnt <= r_dec_cnt + c_DEC_W'(1);
                    end
                end

                if (r_comb_go) begin
                    r_dly1      <= r_i3_lat;
                    r_dly2      <= w_c1;
                    r_dly3      <= w_c2;
                    r_pcm       <= w_pcm_sat;
                    r_pcm_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.sclk        = r_sclk;
    assign bus.pcm_o       = r_pcm;
    assign bus.pcm_valid_o = r_pcm_valid;

endmodule
`default_nettype wire

// File: tb/tb_pdm_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_cic_decimator
// Description : Self-checking bench; CIC output compared with a convolution model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_cic_decimator;

    localparam int c_CLK_DIV = 25;
    localparam int c_DEC     = 64;
    localparam int c_FRAME   = c_DEC * 2 * c_CLK_DIV;
    localparam int c_HLEN    = 3 * (c_DEC - 1) + 1;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    int h[0:c_HLEN-1];
    bit xs[$];

    pdm_cic_decimator_if u_if();

    pdm_cic_decimator #(
        .CLK_DIV (c_CLK_DIV),
        .DEC     (c_DEC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Impulse response of three cascaded length-DEC boxcars.
    task automatic build_h();
        for (int m = 0; m < c_HLEN; m++) h[m] = 0;
        for (int a = 0; a < c_DEC; a++)
            for (int b = 0; b < c_DEC; b++)
                for (int c = 0; c < c_DEC; c++)
                    h[a + b + c]++;
    endtask

    function automatic int model_pcm(input int n);
        int acc = 0;
        for (int m = 0; m < c_HLEN; m++)
            if (n - m >= 1) acc += h[m] * (xs[n - m - 1] ? 1 : -1);
        acc = acc >>> 3;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    function automatic bit gen_bit(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (k % 2) == 1;
            3:       return ((k - 1) % 4) != 3;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Assumes the DUT is idle-cleared; enables it and tracks nout PCM outputs.
    task automatic run_frames(input int mode, input int nout, input bit chk_steady, input int steady);
        int cyc = 0, k = 0, outn = 0, pending = -10, last_valid = -1, first_rise = -1;
        int expv, got;
        bit prev_sclk = 1'b0;
        xs.delete();
        xs.push_back(gen_bit(mode, 1));
        u_if.dat_i = xs[0];
        u_if.en_i  = 1'b1;
        while (outn < nout && cyc < nout * c_FRAME + 400) begin
            @(posedge clk); #1; cyc++;
            if (first_rise < 0 && u_if.sclk) first_rise = cyc;
            if (prev_sclk && !u_if.sclk) begin
                k++;
                if (k % c_DEC == 0) pending = cyc + 1;
                xs.push_back(gen_bit(mode, k + 1));
                u_if.dat_i = xs[k];
            end
            if (cyc == pending) begin
                n_checks++;
                if (u_if.pcm_valid_o !== 1'b1)
                    $display("FAIL valid_latency mode%0d: valid=%b at strobe %0d, required 1", mode, u_if.pcm_valid_o, k);
                else n_pass++;
                outn++;
                if (u_if.pcm_valid_o === 1'b1) begin
                    expv = model_pcm(k);
                    got  = int'(u_if.pcm_o);
                    n_checks++;
                    if (got !== expv)
                        $display("FAIL pcm_model mode%0d out%0d: got %0d, required %0d", mode, outn, got, expv);
                    else n_pass++;
                    if (chk_steady && outn >= 4) begin
                        n_checks++;
                        if (got !== steady)
                            $display("FAIL pcm_steady mode%0d out%0d: got %0d, required %0d", mode, outn, got, steady);
                        else n_pass++;
                    end
                    if (last_valid >= 0) begin
                        n_checks++;
                        if (cyc - last_valid !== c_FRAME)
                            $display("FAIL pulse_spacing mode%0d: got %0d, required %0d", mode, cyc - last_valid, c_FRAME);
                        else n_pass++;
                    end
                    last_valid = cyc;
                end
            end else if (cyc == pending + 1) begin
                n_checks++;
                if (u_if.pcm_valid_o !== 1'b0)
                    $display("FAIL pulse_width mode%0d: valid=%b one cycle after pulse, required 0", mode, u_if.pcm_valid_o);
                else n_pass++;
            end else if (u_if.pcm_valid_o !== 1'b0) begin
                n_checks++;
                $display("FAIL stray_valid mode%0d: valid=%b at strobe %0d, required 0", mode, u_if.pcm_valid_o, k);
            end
            prev_sclk = u_if.sclk;
        end
        n_checks++;
        if (first_rise !== c_CLK_DIV)
            $display("FAIL first_rise mode%0d: got %0d, required %0d", mode, first_rise, c_CLK_DIV);
        else n_pass++;
        n_checks++;
        if (outn < nout)
            $display("FAIL run_timeout mode%0d: got %0d outputs, required %0d", mode, outn, nout);
        else n_pass++;
    endtask

    task automatic restart();
        u_if.en_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // Called #1 after the edge at which the block became active.
    task automatic check_release(input string tag);
        int rise1 = -1, fall1 = -1, rise2 = -1, nvalid = 0;
        bit prev = 1'b0;
        for (int c = 1; c <= 4 * c_CLK_DIV; c++) begin
            @(posedge clk); #1;
            if (!prev && u_if.sclk) begin
                if (rise1 < 0) rise1 = c;
                else if (rise2 < 0) rise2 = c;
            end
            if (prev && !u_if.sclk && fall1 < 0) fall1 = c;
            if (u_if.pcm_valid_o) nvalid++;
            prev = u_if.sclk;
        end
        n_checks++;
        if (rise1 !== c_CLK_DIV) $display("FAIL %s_first_rise: got %0d, required %0d", tag, rise1, c_CLK_DIV);
        else n_pass++;
        n_checks++;
        if (fall1 - rise1 !== c_CLK_DIV) $display("FAIL %s_high_time: got %0d, required %0d", tag, fall1 - rise1, c_CLK_DIV);
        else n_pass++;
        n_checks++;
        if (rise2 - fall1 !== c_CLK_DIV) $display("FAIL %s_low_time: got %0d, required %0d", tag, rise2 - fall1, c_CLK_DIV);
        else n_pass++;
        n_checks++;
        if (nvalid !== 0) $display("FAIL %s_no_valid: got %0d pulses, required 0", tag, nvalid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        u_if.en_i  = 1'b1;
        u_if.dat_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (u_if.sclk !== 1'b0) $display("FAIL reset_sclk: got %b, required 0", u_if.sclk); else n_pass++;
        n_checks++;
        if (u_if.pcm_o !== 16'sd0) $display("FAIL reset_pcm: got %0d, required 0", u_if.pcm_o); else n_pass++;
        n_checks++;
        if (u_if.pcm_valid_o !== 1'b0) $display("FAIL reset_valid: got %b, required 0", u_if.pcm_valid_o); else n_pass++;
    endtask

    task automatic test_divider();
        rst_n = 1'b1;
        check_release("divider");
    endtask

    task automatic test_all_ones();
        restart();
        run_frames(0, 4, 1'b1, 32767);
    endtask

    task automatic test_all_zeros_and_alt();
        restart();
        run_frames(1, 4, 1'b1, -32768);
        restart();
        run_frames(2, 4, 1'b1, 0);
    endtask

    task automatic test_density();
        restart();
        run_frames(3, 4, 1'b1, 16384);
    endtask

    task automatic test_enable_midframe();
        int k = 0, nvalid = 0, nchg = 0, cyc = 0;
        logic signed [15:0] hold;
        bit prev = 1'b0;
        restart();
        u_if.en_i = 1'b1;
        while (k < 30 && cyc < 40 * 2 * c_CLK_DIV) begin
            @(posedge clk); #1; cyc++;
            if (prev && !u_if.sclk) begin
                k++;
                u_if.dat_i = 1'($urandom_range(0, 1));
            end
            prev = u_if.sclk;
        end
        repeat (c_CLK_DIV + 5) begin @(posedge clk); #1; end
        n_checks++;
        if (k !== 30 || u_if.sclk !== 1'b1)
            $display("FAIL en_setup: strobes %0d sclk %b, required 30 and 1", k, u_if.sclk);
        else n_pass++;
        hold      = u_if.pcm_o;
        u_if.en_i = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (u_if.sclk !== 1'b0) $display("FAIL en_drop_sclk: got %b, required 0", u_if.sclk); else n_pass++;
        repeat (100) begin
            @(posedge clk); #1;
            if (u_if.pcm_valid_o) nvalid++;
            if (u_if.pcm_o !== hold) nchg++;
        end
        n_checks++;
        if (nvalid !== 0) $display("FAIL en_drop_valid: got %0d pulses, required 0", nvalid); else n_pass++;
        n_checks++;
        if (nchg !== 0) $display("FAIL en_drop_hold: pcm changed in %0d cycles, required 0", nchg); else n_pass++;
        run_frames(4, 3, 1'b0, 0);
    endtask

    task automatic test_reset_midframe();
        int k = 0, cyc = 0;
        bit prev = 1'b0;
        restart();
        u_if.dat_i = 1'b1;
        u_if.en_i  = 1'b1;
        while (k < 40 && cyc < 50 * 2 * c_CLK_DIV) begin
            @(posedge clk); #1; cyc++;
            if (prev && !u_if.sclk) k++;
            prev = u_if.sclk;
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (u_if.sclk !== 1'b0) $display("FAIL rstmid_sclk: got %b, required 0", u_if.sclk); else n_pass++;
        n_checks++;
        if (u_if.pcm_o !== 16'sd0) $display("FAIL rstmid_pcm: got %0d, required 0", u_if.pcm_o); else n_pass++;
        n_checks++;
        if (u_if.pcm_valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b, required 0", u_if.pcm_valid_o); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_release("rstmid");
    endtask

    initial begin
        rst_n      = 1'b0;
        u_if.en_i  = 1'b0;
        u_if.dat_i = 1'b0;
        build_h();
        test_reset();
        test_divider();
        test_all_ones();
        test_all_zeros_and_alt();
        test_density();
        test_enable_midframe();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

Front-end stage of the microphone path. It generates the PDM microphone bit clock `sclk` and samples the 1-bit PDM stream `dat_i`. A 3rd-order CIC filter decimates the stream to signed 16-bit PCM samples, which are presented with a single-cycle valid strobe to the band-pass filter stage directly downstream.

## Interface
- `CLK_DIV`, default 25: `sclk` half-period in `clk` cycles. At 50 MHz `clk` this gives a 1 MHz `sclk`. Legal range is 2..255.
- `DEC`, default 64: decimation ratio R, counted in PDM samples. Fixed at 64 for this revision; internal widths are derived from it.
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en_i`, input, 1: run enable. When low, the block is held idle and cleared.
- `dat_i`, input, 1: PDM data from the microphone; asynchronous to `clk`.
- `sclk`, output, 1: PDM bit clock to the microphone; 50% duty.
- `pcm_o`, output, 16: signed PCM sample; held between strobes.
- `pcm_valid_o`, output, 1: one-`clk` pulse when `pcm_o` is updated.

## Operation
- **Reset (`rst_n`=0, asynchronous):**
  - `sclk`=0, `pcm_o`=0, `pcm_valid_o`=0.
  - Divider, decimation counter, integrators, comb delays and synchronizer are all cleared.
- **Clock divider:**
  - The counter runs 0..CLK_DIV-1.
  - On wrap, `sclk` toggles.
  - `sclk` is driven straight from a register.
- **Synchronizer:** `dat_i` passes through 2 flops. `d_s` is the output of the second flop.
- **Sample strobe `stb`:**
  - Asserted in the `clk` cycle where the divider wraps while `sclk`=1, i.e. on the `sclk` falling transition.
  - One strobe per `sclk` period.
- **Input mapping:** `d_s`=1 maps to +1 and `d_s`=0 maps to −1, both 20-bit signed.
- **Integrators:**
  - Three cascaded integrators, 20-bit two's complement, wrap-around by design with no saturation.
  - They update only on `stb`: I1+=x, I2+=I1_new, I3+=I2_new. This is a full cascade within the one cycle.
- **Decimation counter:**
  - Counts strobes 0..DEC-1.
  - The strobe with count=DEC-1 is the decimation point, cycle S. The counter then wraps to 0.
- **Comb stage (cycle S+1):**
  - The comb input is the I3 value latched at the end of S.
  - Three cascaded combs, differential delay 1, 20-bit wrap arithmetic. Each comb delay register updates only at decimation points.
- **Output scaling:**
  - y = C3 >>> 3, arithmetic shift.
  - Saturate to [−32768, 32767]; only +32768 actually clips.
- **Full-scale values:** all-ones input gives C3=+262144, so `pcm_o`=32767. All-zeros gives −262144, so `pcm_o`=−32768.
- **`en_i` low (sampled each cycle):**
  - On the next edge: `sclk`=0, divider=0, decimation counter=0, integrators and comb delays=0, `pcm_valid_o`=0.
  - `pcm_o` holds its last value.
  - No strobe is issued in any cycle where `en_i`=0.
- **`en_i` rising:**
  - Operation restarts from the cleared state.
  - The first `sclk` rise comes CLK_DIV cycles later.
- **Reset mid-frame:** the partial frame is discarded and no `pcm_valid_o` pulse is produced for it.

## Timing
- `sclk` period is 2·CLK_DIV `clk` cycles: 50 cycles at the default, high for CLK_DIV and low for CLK_DIV.
- Input latency: a `dat_i` change reaches `d_s` 2 `clk` edges later. The bit used at a strobe is the one `dat_i` held 2 cycles before that strobe.
- Output latency:
  - `pcm_valid_o`=1 and new `pcm_o` are visible in cycle S+2, i.e. 2 `clk` cycles after the decimation strobe.
  - `pcm_valid_o` is high for exactly 1 cycle.
- Output rate: one pulse per DEC·2·CLK_DIV `clk` cycles, which is 3200 at the defaults (15.625 kHz output rate).
- After reset or enable:
  - The first `pcm_valid_o` follows the 64th strobe.
  - The first 3 outputs are filter fill transients. From the 4th output on, a stationary input gives its steady-state value.
- The downstream stage must sample `pcm_o` when `pcm_valid_o`=1. There is no backpressure; samples are never stalled.

## Test plan
- **Divider:** release reset with `en_i`=1 and default parameters. `sclk` first rises 25 cycles after reset release, then the period is 50 cycles at 50% duty; `stb` count equals the `sclk` falling-edge count.
- **All ones:** drive constant `dat_i`=1. Outputs 4 onward = 32767 (saturated). Pulse spacing is exactly 3200 cycles, and each pulse is 2 cycles after the decimating strobe.
- **All zeros:** drive constant `dat_i`=0. Outputs 4 onward = −32768. The alternating pattern 1,0,1,0 (changing once per `sclk` period) gives outputs 4 onward = 0.
- **Density:** drive the repeating pattern 1,1,1,0 per strobe. Outputs 4 onward = 16384. The bench compares against a reference CIC model across random PDM streams, requiring exact bit match.
- **Enable mid-frame:** drop `en_i` at strobe 30 of a frame.
  - `sclk`=0 on the next edge; no `pcm_valid_o` pulse; `pcm_o` holds.
  - Re-enable: the first pulse comes after 64 new strobes.
- **Reset mid-frame:** assert `rst_n`=0 asynchronously between clock edges. All outputs are 0 immediately, with no pulse for the interrupted frame; after release the behaviour matches the divider scenario.
